snes_pad_responder: RTL and testbench
=====================================

SNES_PAD_RESPONDER -- requirements
Module: snes_pad_responder

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 16, giving serial frame length in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving synchronizer depth for host inputs.
REQ-003 The block SHALL have port clk, input, 1 bit, system clock; the block's only clock.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port snes_clk, input, 1 bit, host shift clock; asynchronous to clk, idle high.
REQ-006 The block SHALL have port data_latch, input, 1 bit, host latch pulse; asynchronous to clk, active high.
REQ-007 The block SHALL have port button_data, input, 12 bits, live button state, 1 = pressed, indexed per package constants.
REQ-008 The block SHALL have port serial_data, output, 1 bit, serial button stream to host, active-low (0 = pressed).

Function
REQ-009 The block SHALL pass snes_clk and data_latch through SYNC_STAGES flops and detect edges on the synchronized versions only.
REQ-010 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-011 In IDLE, serial_data SHALL be 1.
REQ-012 While synchronized data_latch is high (LOAD), the block SHALL copy button_data into the frame register every cycle and SHALL drive serial_data = ~button_data[0].
REQ-013 On a synchronized data_latch falling edge, the block SHALL freeze the frame, set the bit counter to 0, and enter SHIFT.
REQ-014 Frame bit k SHALL be ~button_data[k] for k < 12 and 1 for 12 <= k < NUM_BITS.
REQ-015 In SHIFT, serial_data SHALL equal frame bit [counter].
REQ-016 Each synchronized snes_clk rising edge in SHIFT SHALL increment the counter.
REQ-017 serial_data SHALL reflect the new counter value no later than SYNC_STAGES+2 clk cycles after the raw snes_clk rising edge.
REQ-018 Falling edges of snes_clk SHALL cause no state change.
REQ-019 When the counter reaches NUM_BITS, the block SHALL enter DONE with serial_data = 0 and SHALL ignore further snes_clk edges; the counter SHALL NOT wrap.
REQ-020 A data_latch rising edge in any state, including mid-SHIFT, SHALL abort the frame and enter LOAD.
REQ-021 snes_clk edges while latch is high SHALL be ignored.
REQ-022 If a latch rising edge and a snes_clk rising edge occur in the same cycle, the latch SHALL win.
REQ-023 Changes on button_data after the latch falling edge SHALL NOT affect the current frame.

Reset
REQ-024 On reset, the FSM SHALL be IDLE, counter 0, frame all 1s, serial_data 1, and synchronizer flops SHALL take their idle values (snes_clk 1, data_latch 0).
REQ-025 Reset asserted mid-frame SHALL take effect on the next clk edge and SHALL discard the frame; the next frame SHALL start only after a new latch pulse.
REQ-026 Reset SHALL NOT generate spurious edges; edge detect history SHALL be reset to idle levels.

Structure
REQ-027 A shared package SHALL hold the button index constants (B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11), the NUM_BITS default, and the FSM state encoding.
REQ-028 The synchronizer and edge detector SHALL be one sub-module, snes_sync_edge (parameters: depth and idle level; outputs: level, rise, fall), instantiated twice.
REQ-029 serial_data SHALL be driven from a flop.

Verification
REQ-030 Press B and A (button_data=12'h101), latch 12 us, then 16 clock pulses (6 us half-period) -> host samples bits 0..15 = 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1; DONE follows with serial_data=0.
REQ-031 All buttons pressed (12'hFFF) -> bits 0..11 read 0 and bits 12..15 read 1.
REQ-032 Second latch after 8 clocks -> frame restarts; next 16 bits match the button_data captured at the new latch.
REQ-033 button_data toggled every 1 us during SHIFT -> stream equals the value present at the latch falling edge.
REQ-034 Reset pulsed after 5 clocks -> serial_data=1 the next cycle, IDLE; further snes_clk pulses without a latch leave serial_data at 1.
REQ-035 20 clock pulses after the latch -> pulses 16..19 ignored; serial_data stays 0 and the counter stays at 16.

Source files
------------

// File: rtl/snes_pad_responder_pkg.sv
// -----------------------------------------------------------------------------
// snes_pad_responder_pkg
//   Shared definitions for the SNES controller responder:
//     - button index constants (position of each button in button_data and
//       in the serial frame)
//     - default frame length and synchronizer depth
//     - FSM state encoding
//   No ports (package).
// -----------------------------------------------------------------------------
package snes_pad_responder_pkg;

  // Number of physical buttons carried in button_data.
  localparam int NUM_BUTTONS = 12;

  // Button positions; bit k of button_data is shifted out as frame bit k.
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // A standard SNES pad reply is 16 bits: 12 buttons plus 4 trailing 1s.
  localparam int NUM_BITS_DEFAULT    = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/snes_pad_responder_sync_edge.sv
// -----------------------------------------------------------------------------
// snes_sync_edge
//   Multi-flop synchronizer for one asynchronous input followed by an edge
//   detector that works only on the synchronized level.
//
//   Parameters
//     DEPTH      : number of synchronizer flops (>= 1)
//     IDLE_LEVEL : value loaded into every flop (and the edge history) on
//                  reset, so leaving reset never produces a false edge
//   Ports
//     clk   : system clock
//     reset : synchronous active-high reset
//     din   : asynchronous input
//     level : synchronized level
//     rise  : one-cycle pulse on a synchronized 0->1 transition
//     fall  : one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module snes_sync_edge #(
  parameter int   DEPTH      = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] sync_reg;
  logic             prev_reg;

  // Each stage is its own flop so any DEPTH (including 1) elaborates cleanly.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            sync_reg[gi] <= IDLE_LEVEL;
          end else begin
            sync_reg[gi] <= din;
          end
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (reset) begin
            sync_reg[gi] <= IDLE_LEVEL;
          end else begin
            sync_reg[gi] <= sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Edge history starts at the idle level as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= IDLE_LEVEL;
    end else begin
      prev_reg <= sync_reg[DEPTH-1];
    end
  end

  assign level = sync_reg[DEPTH-1];
  assign rise  = sync_reg[DEPTH-1] & ~prev_reg;
  assign fall  = ~sync_reg[DEPTH-1] & prev_reg;

endmodule

// File: rtl/snes_pad_responder.sv
// -----------------------------------------------------------------------------
// snes_pad_responder
//   Emulates an SNES game pad on the controller side of the link. The host
//   pulses data_latch to capture the buttons, then clocks the frame out with
//   snes_clk; one frame bit is presented per host clock, active low.
//
//   Parameters
//     NUM_BITS    : serial frame length in bits (default 16)
//     SYNC_STAGES : synchronizer depth for snes_clk and data_latch
//   Ports
//     clk         : system clock (only clock of the block)
//     reset       : synchronous active-high reset
//     snes_clk    : host shift clock, asynchronous, idles high
//     data_latch  : host latch pulse, asynchronous, active high
//     button_data : live button state, 1 = pressed, indexed per package
//     serial_data : serial reply, 0 = pressed; registered output
// -----------------------------------------------------------------------------
module snes_pad_responder
  import snes_pad_responder_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snes_clk,
  input  logic                   data_latch,
  input  logic [NUM_BUTTONS-1:0] button_data,
  output logic                   serial_data
);

  // Counter must be able to hold NUM_BITS itself (the DONE value).
  localparam int               CNT_W    = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Host input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic clk_level, clk_rise, clk_fall;
  logic latch_level, latch_rise, latch_fall;

  snes_sync_edge #(
    .DEPTH      (SYNC_STAGES),
    .IDLE_LEVEL (1'b1)
  ) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (snes_clk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  snes_sync_edge #(
    .DEPTH      (SYNC_STAGES),
    .IDLE_LEVEL (1'b0)
  ) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .din   (data_latch),
    .level (latch_level),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  // The shift clock's level and falling edge carry no meaning for this
  // protocol; only its rising edge advances the frame.
  logic unused_snes_clk;
  assign unused_snes_clk = &{1'b0, clk_level, clk_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_reg,  state_next;
  logic [CNT_W-1:0]    count_reg,  count_next;
  logic [NUM_BITS-1:0] frame_reg,  frame_next;
  logic                serial_reg, serial_next;

  // Frame image of the live buttons: inverted buttons, then padding 1s.
  logic [NUM_BITS-1:0] frame_live;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_frame
      if (gi < NUM_BUTTONS) begin : g_btn
        assign frame_live[gi] = ~button_data[gi];
      end else begin : g_pad
        assign frame_live[gi] = 1'b1;
      end
    end
  endgenerate

  // One-hot compare of the next counter value against every bit position.
  // This avoids indexing the frame with a counter that is one bit wider than
  // the frame index and can legally hold the out-of-range value NUM_BITS.
  logic [NUM_BITS-1:0] bit_hit;
  logic                sel_bit;

  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_sel
      assign bit_hit[gi] = frame_reg[gi] & (count_next == CNT_W'(gi));
    end
  endgenerate

  assign sel_bit = |bit_hit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    frame_next = frame_reg;

    if (latch_rise) begin
      // A new latch always wins, even over a same-cycle clock edge or an
      // in-flight frame.
      state_next = ST_LOAD;
      count_next = '0;
      frame_next = frame_live;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (latch_fall) begin
            // Frame keeps the copy from the last latch-high cycle.
            state_next = ST_SHIFT;
            count_next = '0;
          end else if (latch_level) begin
            frame_next = frame_live;
          end
        end

        ST_SHIFT: begin
          if (clk_rise) begin
            count_next = count_reg + CNT_ONE;
            if (count_reg == LAST_IDX) begin
              state_next = ST_DONE;
            end
          end
        end

        // IDLE and DONE only leave on a latch rising edge.
        default: begin
        end
      endcase
    end
  end

  // Output is computed from the next state so serial_data updates on the same
  // clk edge as the counter.
  always_comb begin
    serial_next = 1'b1;
    case (state_next)
      ST_IDLE:  serial_next = 1'b1;
      ST_LOAD:  serial_next = ~button_data[0];
      ST_SHIFT: serial_next = sel_bit;
      ST_DONE:  serial_next = 1'b0;
      default:  serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      frame_reg  <= '1;
      serial_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      frame_reg  <= frame_next;
      serial_reg <= serial_next;
    end
  end

  assign serial_data = serial_reg;

endmodule

// File: tb/tb_snes_pad_responder.sv
`timescale 1ns/1ps
module tb_snes_pad_responder;

  // 10 MHz system clock: 1 us = 10 cycles, host half period 6 us = 60 cycles.
  logic        clk = 1'b0;
  logic        reset;
  logic        snes_clk;
  logic        data_latch;
  logic [11:0] button_data;
  logic        serial_data;

  always #50 clk = ~clk;

  snes_pad_responder #(
    .NUM_BITS    (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .snes_clk    (snes_clk),
    .data_latch  (data_latch),
    .button_data (button_data),
    .serial_data (serial_data)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int    kind;   // 0 = serial_data, 1 = bit counter
    int    expv;
    string tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  event     sample_ev;
  int       checks   = 0;
  int       failures = 0;
  int       test_id  = 0;

  task automatic expect_serial(input int expv, input string tag);
    sb_item_t it;
    it.kind = 0;
    it.expv = expv;
    it.tag  = tag;
    sb_q.push_back(it);
    -> sample_ev;
  endtask

  task automatic expect_count(input int expv, input string tag);
    sb_item_t it;
    it.kind = 1;
    it.expv = expv;
    it.tag  = tag;
    sb_q.push_back(it);
    -> sample_ev;
  endtask

  // Monitor: whenever the host samples, pop and compare.
  initial begin
    sb_item_t it;
    int       actual;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        if (it.kind == 0) actual = int'(serial_data);
        else              actual = int'(dut.count_reg);
        checks++;
        if (actual != it.expv) begin
          failures++;
          $display("FAIL %s actual=%0d required=%0d t=%0t", it.tag, actual, it.expv, $time);
        end else begin
          $display("ok   %s value=%0d t=%0t", it.tag, actual, $time);
        end
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Host model
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_bit(input logic [15:0] s, input int k);
    if (k < 16) return int'(s[k]);
    return 0;
  endfunction

  // 12 us latch pulse; with noise, the shift clock is toggled while latched.
  task automatic do_latch(input logic [11:0] btn, input bit noise);
    button_data = btn;
    data_latch  = 1'b1;
    if (noise) begin
      repeat (3) begin
        wait_cyc(20);
        snes_clk = 1'b0;
        wait_cyc(15);
        snes_clk = 1'b1;
      end
      wait_cyc(15);
    end else begin
      wait_cyc(120);
    end
    data_latch = 1'b0;
  endtask

  // Host clocks out npulses bits; bit k is sampled just before rising edge k.
  // With fast set, the next bit is also sampled SYNC_STAGES+2 cycles after
  // each rising edge to check response latency.
  task automatic shift_frame(input logic [15:0] exp, input int npulses, input bit fast);
    wait_cyc(60);
    for (int k = 0; k < npulses; k++) begin
      snes_clk = 1'b0;
      wait_cyc(60);
      expect_serial(exp_bit(exp, k), $sformatf("t%0d_bit%0d", test_id, k));
      snes_clk = 1'b1;
      if (fast) begin
        wait_cyc(4);
        expect_serial(exp_bit(exp, k + 1), $sformatf("t%0d_lat%0d", test_id, k + 1));
        wait_cyc(56);
      end else begin
        wait_cyc(60);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    snes_clk    = 1'b1;
    data_latch  = 1'b0;
    button_data = 12'h000;
    wait_cyc(3);
    expect_serial(1, "reset_serial");
    expect_count(0, "reset_count");
    reset = 1'b0;
    wait_cyc(10);
    expect_serial(1, "idle_serial");

    // T1: B and A pressed -> 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1, then DONE.
    test_id = 1;
    do_latch(12'h101, 1'b0);
    shift_frame(16'hFEFE, 16, 1'b1);
    wait_cyc(60);
    expect_serial(0, "t1_done");
    expect_count(16, "t1_count");

    // T2: all buttons -> bits 0..11 zero, 12..15 one.
    test_id = 2;
    do_latch(12'hFFF, 1'b0);
    shift_frame(16'hF000, 16, 1'b0);
    wait_cyc(60);
    expect_serial(0, "t2_done");

    // T3: relatch after 8 bits; new frame follows the new buttons.
    test_id = 3;
    do_latch(12'h0F0, 1'b0);
    shift_frame(16'hFF0F, 8, 1'b0);
    test_id = 31;
    do_latch(12'h00A, 1'b0);
    shift_frame(16'hFFF5, 16, 1'b0);
    wait_cyc(60);
    expect_serial(0, "t3_done");

    // T4: buttons toggle every 1 us during shift; frame holds latched value.
    test_id = 4;
    do_latch(12'h5A5, 1'b0);
    fork
      shift_frame(16'hFA5A, 16, 1'b0);
      begin
        wait_cyc(10);
        repeat (190) begin
          button_data = ~button_data;
          wait_cyc(10);
        end
      end
    join
    wait_cyc(60);
    expect_serial(0, "t4_done");

    // T5: reset after 5 clocks; serial returns to 1 and stays there.
    test_id = 5;
    do_latch(12'h101, 1'b0);
    shift_frame(16'hFEFE, 5, 1'b0);
    reset = 1'b1;
    wait_cyc(1);
    expect_serial(1, "t5_rst_serial");
    expect_count(0, "t5_rst_count");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      snes_clk = 1'b0;
      wait_cyc(60);
      expect_serial(1, $sformatf("t5_nolatch%0d", k));
      snes_clk = 1'b1;
      wait_cyc(60);
    end
    expect_serial(1, "t5_idle");

    // T6: clock edges during latch ignored; 20 pulses, last 4 ignored.
    test_id = 6;
    do_latch(12'h820, 1'b1);
    shift_frame(16'hF7DF, 20, 1'b0);
    expect_serial(0, "t6_done");
    expect_count(16, "t6_count");

    wait_cyc(10);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
